inst_mem_resp: RTL
==================

Name: inst_mem_resp

Overview:
- Instruction-memory responder: the memory side of the fetch interface.
- Serves word-indexed fetch requests from the fetch stage through a valid/ready request/response handshake.
- Adds a configurable wait-state latency and a program-load write port.
- Replaces the combinational instruction ROM, so the fetch stage can be verified against realistic memory timing.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit instruction words stored
- LATENCY, 1, cycles from request accept to resp_valid; legal range 1..15
- NOP_INST, 32'h00000013, instruction returned on out-of-range access

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept request this cycle
- req_addr  input  32  word index (PC counts in words)
- resp_valid  output  1  response data valid
- resp_ready  input  1  fetch side accepts response
- resp_inst  output  32  fetched instruction
- resp_err  output  1  address was out of range
- load_we  input  1  program-load write strobe
- load_addr  input  DEPTH_LOG2  load word index
- load_data  input  32  load word

Behaviour:
- Reset: rst_n sampled low on a rising edge forces state=IDLE, wait counter=0, resp_valid=0, resp_inst=0, resp_err=0.
- Memory array is not cleared by reset; contents persist across reset.
- Reset mid-operation discards any in-flight request; no response is produced for it.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). It is combinational from state and resp_ready only; it never depends on req_valid.
- Accept occurs when req_valid && req_ready. On accept:
  - latch addr;
  - if LATENCY==1, next state is RESP;
  - otherwise next state is WAIT with counter=LATENCY-2.
- WAIT: counter decrements each cycle; at counter==0 the next state is RESP.
- Data fetch: on the cycle the FSM transitions into RESP, resp_inst/resp_err are registered from the array using the latched addr.
- Out of range (latched addr >= 2^DEPTH_LOG2, upper bits nonzero): resp_inst=NOP_INST, resp_err=1. The array is not accessed.
- RESP: resp_valid=1; resp_inst and resp_err are held stable until resp_ready.
  - resp_ready=1 with no new accept: next state is IDLE; resp_valid falls the next cycle.
  - resp_ready=1 with a simultaneous accept: follows the accept transition, so back-to-back throughput is 1 response/cycle at LATENCY=1.
- Latency: request accepted at rising edge N gives resp_valid=1 from edge N+LATENCY.
- Load port: when load_we=1, mem[load_addr] <= load_data at the edge. Loads are independent of FSM state.
- Load write coinciding with a fetch read of the same word (the cycle entering RESP): the read returns the old contents (read-before-write). The new value is visible to later requests.
- Only valid/ready handshakes are used; no request is ever dropped or duplicated. resp_inst is a don't-care when resp_valid=0 but is held at its last value.

Decomposition:
- Shared defines header holds:
  - the NOP encoding constant;
  - the FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the reset-level define used by the rest of the core.
- One sub-module: inst_mem_array, a 2^DEPTH_LOG2 x 32 storage with one synchronous write port (load) and one synchronous read port with an enable. It has read-before-write semantics and no reset.
- The FSM, wait counter and response registers live in the top module.

Test Plan:
- Load mem[0..3]=32'h00100093,32'h00200113,32'h00308193,32'h00000073; LATENCY=1; req_addr=0..3 back-to-back with resp_ready=1 -> resp_inst returns the four words in order, one per cycle, each one cycle after accept; req_ready stays high throughout.
- LATENCY=3, single req_addr=2 at edge N -> req_ready=0 on edges N+1..N+2; resp_valid=1 at N+3 with resp_inst=32'h00308193, resp_err=0.
- Backpressure: resp_ready=0 for 5 cycles during RESP -> resp_valid stays 1, resp_inst stays constant, req_ready=0; after resp_ready=1 the next request is accepted that same cycle.
- Out-of-range: req_addr=32'h00000400 (DEPTH_LOG2=10) -> resp_inst=32'h00000013, resp_err=1; a following req_addr=1 returns 32'h00200113, resp_err=0.
- Load/read collision: mem[5]=32'hAAAAAAAA; fetch addr 5 with load_we=1, load_addr=5, load_data=32'h55555555 on the cycle entering RESP -> response 32'hAAAAAAAA; a repeat fetch of 5 returns 32'h55555555.
- Reset mid-WAIT (LATENCY=4, rst_n low one cycle) -> resp_valid=0 and req_ready=1 after release; no stale response ever appears; mem contents preserved (fetch addr 0 returns 32'h00100093).

Source files
------------

// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: shared constants and FSM encoding for the instruction-memory responder.
// Contents: default NOP encoding, reset assertion level, responder state type.
package inst_mem_resp_pkg;

    localparam logic [31:0] NOP_ENC = 32'h00000013;
    localparam logic RST_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/inst_mem_resp_if.sv
// inst_mem_resp_if: fetch request/response handshake bundle.
// master = fetch stage (drives req_valid/req_addr/resp_ready), slave = memory responder.
interface inst_mem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/inst_mem_array.sv
// inst_mem_array: 2^DEPTH_LOG2 x 32 storage, one sync write port, one sync enabled read port.
// Ports: clk; we/waddr/wdata write; re/raddr read request; rdata registered read data.
// A same-edge read and write of one word returns the old contents; no reset.
module inst_mem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction-memory responder with wait-state latency and a program-load port.
// Ports: clk; rst_n sync active-low; bus (slave) fetch handshake;
//        load_we/load_addr/load_data program-load write.
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] NOP_INST   = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_mem_resp_if.slave        bus,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic        filled;
    logic        err_q;
    logic [31:0] rdata;
    logic        accept;
    logic        enter;
    logic [31:0] fetch_addr;
    logic        oor;

    assign bus.req_ready  = state == IDLE || (state == RESP && bus.resp_ready);
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = err_q;
    // filled distinguishes the post-reset zero from array data that has no reset
    assign bus.resp_inst  = err_q ? NOP_INST : filled ? rdata : '0;

    assign accept = bus.req_valid && bus.req_ready;
    assign enter  = (accept && LATENCY == 1) || (state == WAIT && cnt == '0);
    // with single-cycle latency the fetch happens on the accept edge, before addr_q holds it
    assign fetch_addr = state == WAIT ? addr_q : bus.req_addr;
    assign oor = |fetch_addr[31:DEPTH_LOG2];

    inst_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .we    (load_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (enter && !oor),
        .raddr (fetch_addr[DEPTH_LOG2-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst_n == RST_LEVEL) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            filled <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                state  <= LATENCY == 1 ? RESP : WAIT;
                cnt    <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == '0) state <= RESP;
            end else if (state == RESP && bus.resp_ready) begin
                state <= IDLE;
            end
            if (enter) begin
                err_q  <= oor;
                filled <= 1'b1;
            end
        end
    end

endmodule
